// File: rtl/axi_up_desc_queue_if.sv
// Push channel and copy-controller command channel of the descriptor queue.
// The queue sits on the slave modport; software and the controller on master.
interface axi_up_desc_queue_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int SIZE_WIDTH = 16
);
  logic                  push_valid_i;
  logic                  push_ready_o;
  logic [ADDR_WIDTH-1:0] push_src_i;
  logic [ADDR_WIDTH-1:0] push_dst_i;
  logic [SIZE_WIDTH-1:0] push_size_i;

  logic [ADDR_WIDTH-1:0] src_addr_o;
  logic [ADDR_WIDTH-1:0] dst_addr_o;
  logic [SIZE_WIDTH-1:0] size_o;
  logic                  trigger_pulse_o;
  logic                  ctrl_busy_i;

  modport slave (
    input  push_valid_i, push_src_i, push_dst_i, push_size_i, ctrl_busy_i,
    output push_ready_o, src_addr_o, dst_addr_o, size_o, trigger_pulse_o
  );

  modport master (
    output push_valid_i, push_src_i, push_dst_i, push_size_i, ctrl_busy_i,
    input  push_ready_o, src_addr_o, dst_addr_o, size_o, trigger_pulse_o
  );
endinterface

// File: rtl/axi_up_desc_queue.sv
// Descriptor queue and sequencer feeding the user-plugin AXI copy controller.
// Optional start timeout (sticky err_o, discard head) enabled by UP_DESC_TIMEOUT_EN.
module axi_up_desc_queue #(
  parameter int ADDR_WIDTH = 32,
  parameter int SIZE_WIDTH = 16,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                   ACLK,
  input  logic                   ARESETn,
  axi_up_desc_queue_if.slave     bus,
  input  logic                   enable_i,
  input  logic                   flush_pulse_i,
  input  logic                   clr_int_pulse_i,
  input  logic                   int_en_i,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   active_o,
  output logic [CNT_WIDTH-1:0]   done_cnt_o,
  output logic                   err_o,
  output logic                   int_pending_o,
  output logic                   int_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]     FULL_COUNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]     CNT_ONE    = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0]   PTR_ONE    = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] DONE_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE} state_t;

  state_t                state;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
  logic [PTR_W:0]        count, count_next;
  logic                  push_ready;
  logic                  trigger;
  logic [ADDR_WIDTH-1:0] src_q, dst_q;
  logic [SIZE_WIDTH-1:0] size_q;
  logic [CNT_WIDTH-1:0]  done_cnt;
  logic                  int_pending;

  logic                  push_fire, pop, timeout, retire, start_issue;

  logic [ADDR_WIDTH-1:0] src_mem  [DEPTH];
  logic [ADDR_WIDTH-1:0] dst_mem  [DEPTH];
  logic [SIZE_WIDTH-1:0] size_mem [DEPTH];

  always_comb begin
    push_fire   = bus.push_valid_i & push_ready & ~flush_pulse_i;
    pop         = (state == WAIT_DONE) & ~bus.ctrl_busy_i;
    retire      = pop | timeout;
    start_issue = (state == IDLE) & enable_i & (count != '0) & ~bus.ctrl_busy_i
                  & ~flush_pulse_i;

    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    count_next  = count;
    if (flush_pulse_i) begin
      if (state == IDLE) begin
        wr_ptr_next = '0;
        rd_ptr_next = '0;
        count_next  = '0;
      end else if (retire) begin
        // The in-flight head finishes in the flush cycle, so nothing is kept.
        rd_ptr_next = rd_ptr + PTR_ONE;
        wr_ptr_next = rd_ptr + PTR_ONE;
        count_next  = '0;
      end else begin
        wr_ptr_next = rd_ptr + PTR_ONE;
        count_next  = CNT_ONE;
      end
    end else begin
      if (retire)    rd_ptr_next = rd_ptr + PTR_ONE;
      if (push_fire) wr_ptr_next = wr_ptr + PTR_ONE;
      case ({push_fire, retire})
        2'b10:   count_next = count + CNT_ONE;
        2'b01:   count_next = count - CNT_ONE;
        default: count_next = count;
      endcase
    end
  end

  // NOTE: descriptor storage has no reset; an entry is only read after it was written.
  always_ff @(posedge ACLK) begin
    if (push_fire) begin
      src_mem[wr_ptr]  <= bus.push_src_i;
      dst_mem[wr_ptr]  <= bus.push_dst_i;
      size_mem[wr_ptr] <= bus.push_size_i;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      push_ready  <= 1'b0;
      trigger     <= 1'b0;
      src_q       <= '0;
      dst_q       <= '0;
      size_q      <= '0;
      done_cnt    <= '0;
      int_pending <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr_next;
      rd_ptr     <= rd_ptr_next;
      count      <= count_next;
      push_ready <= (count_next != FULL_COUNT);
      trigger    <= 1'b0;

      case (state)
        IDLE: begin
          if (start_issue) begin
            state   <= ISSUE;
            trigger <= 1'b1;
            src_q   <= src_mem[rd_ptr];
            dst_q   <= dst_mem[rd_ptr];
            size_q  <= size_mem[rd_ptr];
          end
        end
        ISSUE:      state <= WAIT_START;
        WAIT_START: begin
          if (bus.ctrl_busy_i) state <= WAIT_DONE;
          else if (timeout)    state <= IDLE;
        end
        WAIT_DONE: begin
          if (pop) begin
            state    <= IDLE;
            done_cnt <= done_cnt + DONE_ONE;
          end
        end
        default: state <= IDLE;
      endcase

      // NOTE: non-blocking assignments; the later set overrides a same-cycle clear.
      if (clr_int_pulse_i)              int_pending <= 1'b0;
      if (retire && count_next == '0)   int_pending <= 1'b1;
    end
  end

`ifdef UP_DESC_TIMEOUT_EN
  logic [3:0] timer;
  logic       err_q;

  // timer holds the number of cycles since the trigger cycle.
  assign timeout = (state == WAIT_START) & ~bus.ctrl_busy_i & (timer == 4'd14);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      timer <= '0;
      err_q <= 1'b0;
    end else begin
      if (start_issue)                                timer <= '0;
      else if (state == ISSUE || state == WAIT_START) timer <= timer + 4'd1;
      if (clr_int_pulse_i) err_q <= 1'b0;
      if (timeout)         err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign timeout = 1'b0;
  assign err_o   = 1'b0;
`endif

  assign bus.push_ready_o    = push_ready;
  assign bus.src_addr_o      = src_q;
  assign bus.dst_addr_o      = dst_q;
  assign bus.size_o          = size_q;
  assign bus.trigger_pulse_o = trigger;

  assign count_o       = count;
  assign active_o      = (state != IDLE);
  assign done_cnt_o    = done_cnt;
  assign int_pending_o = int_pending;
  assign int_o         = int_en_i & int_pending;

endmodule

// File: tb/tb_axi_up_desc_queue.sv
// Self-checking bench for axi_up_desc_queue: directed scenarios plus random traffic
// against a queue-based reference model and a simple copy-controller model.
module tb_axi_up_desc_queue;
  localparam int AW    = 32;
  localparam int SW    = 16;
  localparam int DEPTH = 4;
  localparam int CW    = 8;
  localparam int QW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [SW-1:0] size;
  } desc_t;

  logic ACLK    = 1'b0;
  logic ARESETn = 1'b0;
  logic enable_i, flush_pulse_i, clr_int_pulse_i, int_en_i;
  logic [QW-1:0] count_o;
  logic          active_o;
  logic [CW-1:0] done_cnt_o;
  logic          err_o, int_pending_o, int_o;

  always #5 ACLK = ~ACLK;

  axi_up_desc_queue_if #(.ADDR_WIDTH(AW), .SIZE_WIDTH(SW)) bus ();

  axi_up_desc_queue #(
    .ADDR_WIDTH(AW), .SIZE_WIDTH(SW), .DEPTH(DEPTH), .CNT_WIDTH(CW)
  ) dut (
    .ACLK            (ACLK),
    .ARESETn         (ARESETn),
    .bus             (bus),
    .enable_i        (enable_i),
    .flush_pulse_i   (flush_pulse_i),
    .clr_int_pulse_i (clr_int_pulse_i),
    .int_en_i        (int_en_i),
    .count_o         (count_o),
    .active_o        (active_o),
    .done_cnt_o      (done_cnt_o),
    .err_o           (err_o),
    .int_pending_o   (int_pending_o),
    .int_o           (int_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the queue of accepted, not yet retired descriptors.
  desc_t         q[$];
  bit            m_ready_en, m_inflight, m_trig, m_seen;
  int            m_age;
  desc_t         m_out;
  logic [CW-1:0] m_done;
  bit            m_int, m_err;

  // Stimulus and controller model.
  bit    s_push, s_en, s_flush, s_clr, s_inten;
  bit    ext_busy, clr_on_pop, ctrl_dead;
  desc_t s_desc;
  int    busy_len = 6;
  int    busy_rem = 0;
  int    trig_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("trigger",     64'(bus.trigger_pulse_o), 64'(m_trig));
    check("count",       64'(count_o),             64'(q.size()));
    check("push_ready",  64'(bus.push_ready_o),    64'(m_ready_en && q.size() != DEPTH));
    check("active",      64'(active_o),            64'(m_inflight));
    check("done_cnt",    64'(done_cnt_o),          64'(m_done));
    check("int_pending", 64'(int_pending_o),       64'(m_int));
    check("int",         64'(int_o),               64'(int_en_i & m_int));
    check("err",         64'(err_o),               64'(m_err));
    check("src_addr",    64'(bus.src_addr_o),      64'(m_out.src));
    check("dst_addr",    64'(bus.dst_addr_o),      64'(m_out.dst));
    check("size",        64'(bus.size_o),          64'(m_out.size));
  endtask

  task automatic model_step(input bit busy);
    bit push_ok, pop, tmo, issue;
    push_ok = s_push && m_ready_en && (q.size() != DEPTH) && !s_flush;
    pop     = m_inflight && m_seen && !busy;
    tmo     = 1'b0;
`ifdef UP_DESC_TIMEOUT_EN
    tmo     = m_inflight && !m_trig && !m_seen && !busy && (m_age == 14);
`endif
    issue   = !m_inflight && s_en && (q.size() > 0) && !busy && !s_flush;
    if (issue) m_out = q[0];

    if (s_flush) begin
      if (!m_inflight || pop || tmo) q.delete();
      else while (q.size() > 1) void'(q.pop_back());
    end else begin
      if (pop || tmo) void'(q.pop_front());
      if (push_ok)    q.push_back(s_desc);
    end

    if (pop) m_done = m_done + 8'd1;
    if (s_clr) begin
      m_int = 1'b0;
      m_err = 1'b0;
    end
    if ((pop || tmo) && q.size() == 0) m_int = 1'b1;
    if (tmo) m_err = 1'b1;

    if (pop || tmo) begin
      m_inflight = 1'b0;
      m_seen     = 1'b0;
      m_trig     = 1'b0;
    end else begin
      if (m_inflight && !m_trig && busy) m_seen = 1'b1;
      m_age++;
      m_trig = issue;
      if (issue) begin
        m_inflight = 1'b1;
        m_age      = 0;
      end
    end
    m_ready_en = 1'b1;
  endtask

  // One clock cycle: check, drive at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    bit busy;
    check_outputs();
    if (bus.trigger_pulse_o) trig_cnt++;
    busy = ext_busy || (busy_rem > 0);
    if (busy_rem > 0) busy_rem--;
    if (bus.trigger_pulse_o && !ctrl_dead) busy_rem = busy_len;
    if (clr_on_pop && m_inflight && m_seen && !busy) begin
      s_clr      = 1'b1;
      clr_on_pop = 1'b0;
    end
    bus.ctrl_busy_i  = busy;
    bus.push_valid_i = s_push;
    bus.push_src_i   = s_desc.src;
    bus.push_dst_i   = s_desc.dst;
    bus.push_size_i  = s_desc.size;
    enable_i         = s_en;
    flush_pulse_i    = s_flush;
    clr_int_pulse_i  = s_clr;
    int_en_i         = s_inten;
    @(posedge ACLK);
    model_step(busy);
    s_push  = 1'b0;
    s_flush = 1'b0;
    s_clr   = 1'b0;
    @(negedge ACLK);
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic push_desc(input logic [AW-1:0] src, input logic [AW-1:0] dst,
                           input logic [SW-1:0] size);
    s_desc.src  = src;
    s_desc.dst  = dst;
    s_desc.size = size;
    s_push      = 1'b1;
    cycle();
  endtask

  task automatic clear_int();
    s_clr = 1'b1;
    cycle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, d0;
    bus.push_valid_i = 1'b0;
    bus.push_src_i   = '0;
    bus.push_dst_i   = '0;
    bus.push_size_i  = '0;
    bus.ctrl_busy_i  = 1'b0;
    enable_i = 1'b0; flush_pulse_i = 1'b0; clr_int_pulse_i = 1'b0; int_en_i = 1'b0;
    q.delete();
    m_ready_en = 0; m_inflight = 0; m_trig = 0; m_seen = 0; m_age = 0;
    m_out = '0; m_done = '0; m_int = 0; m_err = 0;
    s_push = 0; s_en = 0; s_flush = 0; s_clr = 0; s_inten = 0; s_desc = '0;
    ext_busy = 0; clr_on_pop = 0; ctrl_dead = 0;

    // Reset state.
    repeat (3) begin
      @(negedge ACLK);
      check_outputs();
    end
    ARESETn = 1'b1;
    cycle();

    // Three chained transfers with interrupt.
    s_en = 1'b1; s_inten = 1'b1; busy_len = 6;
    t0 = trig_cnt;
    for (int i = 0; i < 3; i++)
      push_desc(32'h1000 * (i + 1), 32'h8000 + 32'h1000 * i, 16'h10);
    run(50);
    check("t1_triggers", 64'(trig_cnt - t0), 64'd3);
    check("t1_done",     64'(done_cnt_o),    64'd3);
    check("t1_count",    64'(count_o),       64'd0);
    check("t1_int_pend", 64'(int_pending_o), 64'd1);
    check("t1_int",      64'(int_o),         64'd1);

    // Fill beyond DEPTH while disabled, then drain.
    s_en = 1'b0;
    clear_int();
    for (int i = 0; i < 5; i++)
      push_desc($urandom(), $urandom(), SW'($urandom()));
    check("t2_count_full", 64'(count_o),          64'd4);
    check("t2_not_ready",  64'(bus.push_ready_o), 64'd0);
    s_en = 1'b1; busy_len = 3;
    t0 = trig_cnt;
    run(50);
    check("t2_triggers", 64'(trig_cnt - t0), 64'd4);
    check("t2_done",     64'(done_cnt_o),    64'd7);

    // Flush during WAIT_DONE keeps only the in-flight head.
    s_en = 1'b0; busy_len = 6;
    clear_int();
    for (int i = 0; i < 3; i++)
      push_desc($urandom(), $urandom(), SW'($urandom()));
    s_en = 1'b1;
    d0 = int'(done_cnt_o);
    for (int i = 0; i < 20 && !m_seen; i++) cycle();
    check("t3_in_flight", 64'(active_o), 64'd1);
    s_flush = 1'b1;
    cycle();
    check("t3_flush_count", 64'(count_o), 64'd1);
    run(30);
    check("t3_count",    64'(count_o),                  64'd0);
    check("t3_done",     64'(int'(done_cnt_o) - d0),    64'd1);
    check("t3_int_pend", 64'(int_pending_o),            64'd1);

    // Clear in the completion cycle loses to the set.
    clear_int();
    check("t4_cleared", 64'(int_pending_o), 64'd0);
    clr_on_pop = 1'b1;
    push_desc(32'hA000, 32'hB000, 16'h40);
    run(20);
    check("t4_set_wins", 64'(int_pending_o), 64'd1);
    clear_int();
    check("t4_clr_later", 64'(int_pending_o), 64'd0);

    // Externally busy controller blocks issue.
    ext_busy = 1'b1;
    t0 = trig_cnt;
    push_desc(32'hC000, 32'hD000, 16'h20);
    run(6);
    check("t5_no_trigger", 64'(trig_cnt - t0), 64'd0);
    check("t5_count",      64'(count_o),       64'd1);
    ext_busy = 1'b0;
    cycle();
    check("t5_trigger_after_busy", 64'(bus.trigger_pulse_o), 64'd1);
    run(20);

`ifdef UP_DESC_TIMEOUT_EN
    // Controller never answers: timeout discards the head.
    ctrl_dead = 1'b1;
    clear_int();
    d0 = int'(done_cnt_o);
    push_desc(32'hE000, 32'hF000, 16'h08);
    run(25);
    check("t6_err",   64'(err_o),                   64'd1);
    check("t6_done",  64'(int'(done_cnt_o) - d0),   64'd0);
    check("t6_count", 64'(count_o),                 64'd0);
    ctrl_dead = 1'b0;
    clear_int();
    check("t6_err_clr", 64'(err_o), 64'd0);
`endif

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      s_push      = ($urandom_range(0, 1) == 1);
      s_desc.src  = $urandom();
      s_desc.dst  = $urandom();
      s_desc.size = SW'($urandom());
      s_en        = ($urandom_range(0, 9) != 0);
      s_flush     = ($urandom_range(0, 49) == 0);
      s_clr       = ($urandom_range(0, 19) == 0);
      s_inten     = ($urandom_range(0, 1) == 1);
      if (i % 100 == 0) busy_len = $urandom_range(1, 6);
      ext_busy    = (i % 200 >= 185);
      cycle();
    end
    ext_busy = 1'b0;
    run(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_up_desc_queue.md
Name: axi_up_desc_queue

Overview:
- Descriptor queue and sequencer in front of the user-plugin AXI copy controller.
- Software pushes up to DEPTH transfer descriptors (src, dst, size). The block issues them one at a time through the controller's src/dst/size inputs and trigger pulse, then waits for the controller's busy to fall.
- Raises one chain-complete interrupt when the queue drains, replacing per-transfer software polling.

Parameters:
- ADDR_WIDTH, 32, width of src/dst byte addresses.
- SIZE_WIDTH, 16, width of the size field, passed verbatim to the controller.
- DEPTH, 4, number of descriptor entries; power of 2, at least 2.
- CNT_WIDTH, 8, width of the completed-transfer counter.

Ports:
- ACLK  in  1  clock.
- ARESETn  in  1  asynchronous active-low reset.
- push_valid_i  in  1  descriptor push request.
- push_ready_o  out  1  queue can accept a descriptor.
- push_src_i  in  ADDR_WIDTH  source byte address.
- push_dst_i  in  ADDR_WIDTH  destination byte address.
- push_size_i  in  SIZE_WIDTH  transfer size field.
- enable_i  in  1  level; allows issuing descriptors.
- flush_pulse_i  in  1  drops all entries not yet issued.
- clr_int_pulse_i  in  1  clears the interrupt pending bit.
- int_en_i  in  1  interrupt enable.
- src_addr_o  out  ADDR_WIDTH  to controller src_addr_i.
- dst_addr_o  out  ADDR_WIDTH  to controller dst_addr_i.
- size_o  out  SIZE_WIDTH  to controller size_i.
- trigger_pulse_o  out  1  to controller cmd_trigger_pulse_i.
- ctrl_busy_i  in  1  from controller status_busy_o.
- count_o  out  $clog2(DEPTH)+1  entries queued, including the in-flight entry.
- active_o  out  1  sequencer not in IDLE.
- done_cnt_o  out  CNT_WIDTH  completed transfers; wraps.
- err_o  out  1  sticky timeout error.
- int_pending_o  out  1  chain-complete pending.
- int_o  out  1  int_en_i & int_pending_o.

Behaviour:
- Reset values: all outputs 0; queue empty; FSM in IDLE.
  - push_ready_o = (count_o != DEPTH), so it is 1 one cycle after reset.
- Queue storage:
  - Circular buffer with write and read pointers of log2(DEPTH) bits; count is tracked separately.
  - A push happens when push_valid_i & push_ready_o are both high on a clock edge.
  - When full, push_ready_o=0 and push attempts have no effect.
  - Push and pop in the same cycle: count unchanged.
  - push_ready_o comes from the registered count only, so a pop does not create same-cycle room.
- Head entry: stays in the queue, counted in count_o, until its transfer completes.
- src_addr_o/dst_addr_o/size_o: registered. Loaded from the head entry on the IDLE->ISSUE transition and held until the next load.
- FSM states:
  - IDLE: go to ISSUE when enable_i & count>0 & ~ctrl_busy_i.
  - ISSUE: trigger_pulse_o=1 for exactly this one cycle; go to WAIT_START.
  - WAIT_START: go to WAIT_DONE when ctrl_busy_i=1. The controller raises busy the cycle after the trigger, so nominal dwell is one cycle.
  - WAIT_DONE: when ctrl_busy_i=0:
    - pop the head;
    - done_cnt_o+1, wrapping at 2^CNT_WIDTH;
    - go to IDLE.
- Back-to-back issue: IDLE re-issues on the next cycle if the conditions hold. The next trigger follows busy falling by 2 cycles: WAIT_DONE->IDLE->ISSUE.
- enable_i=0: does not abort an in-flight transfer. It only blocks the IDLE->ISSUE transition.
- flush_pulse_i:
  - In IDLE: count goes to 0, both pointers reset.
  - Otherwise: keeps only the in-flight head, so count becomes 1 and the write pointer = read pointer + 1.
  - Flush has priority over a same-cycle push; the push is dropped.
  - Flush does not set the interrupt.
- Interrupt:
  - int_pending_o is set on a WAIT_DONE pop that leaves count 0.
  - clr_int_pulse_i clears it. If set and clear occur in the same cycle, set wins.
  - int_o = int_en_i & int_pending_o, combinational.
- External trigger: if the controller is busy from a direct software trigger while the FSM is in IDLE, the block waits; it never issues while ctrl_busy_i=1.
- Reset mid-operation: all state is lost. Reset of the controller is expected on the same ARESETn.

Optional Feature:
- Macro: UP_DESC_TIMEOUT_EN.
- With the macro defined:
  - A 4-bit counter runs in WAIT_START.
  - If ctrl_busy_i is not seen within 15 cycles of ISSUE: set err_o (sticky, cleared only by clr_int_pulse_i), pop and discard the head, do not increment done_cnt_o, return to IDLE.
  - If that pop empties the queue, int_pending_o is set.
- Without the macro: err_o is tied 0 and WAIT_START waits indefinitely.

Test Plan:
- Reset, then push 3 descriptors (src 0x1000/0x2000/0x3000, dst 0x8000..., size 0x10) with enable_i=1 and a controller model holding busy 6 cycles.
  - Expect 3 trigger pulses, each with matching outputs.
  - done_cnt_o=3, count_o=0, int_pending_o=1 one cycle after the third busy fall.
  - With int_en_i=1, int_o=1.
- Push 5 entries with enable_i=0 and DEPTH=4 → push_ready_o=0 after the 4th; 5th rejected; count_o=4.
  - Then enable: exactly 4 transfers.
- Issue 1 of 3 queued entries, pulse flush_pulse_i during WAIT_DONE → count_o=1.
  - After completion count_o=0, done_cnt_o=1, int_pending_o=1.
- In the completion cycle, pulse clr_int_pulse_i together with the final pop → int_pending_o=1 (set wins).
  - A later clr pulse → 0.
- Hold ctrl_busy_i=1 externally, push 1 entry → no trigger until busy falls.
  - Trigger appears 1 cycle after busy falls.
- UP_DESC_TIMEOUT_EN: controller model never asserts busy → err_o=1 at cycle 15 after ISSUE; head discarded; done_cnt_o unchanged.
